// File: rtl/pdp11_pkg.sv
// Shared types and constants for the PDP-11 style front end.
// IFETCH_ODD_TRAP_EN adds the ERR state used by the odd-PC trap.
package pdp11_pkg;

    localparam int WORD_W = 16;

    localparam logic [2:0] REG_PC = 3'd7;
    localparam logic [2:0] REG_SP = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WB,
        HOLD
`ifdef IFETCH_ODD_TRAP_EN
        ,
        ERR
`endif
    } fetch_state_e;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: reads the word at PC, writes PC+PC_INC back, hands ir to decode.
// Build with IFETCH_ODD_TRAP_EN to trap on odd PC instead of fetching it.
module ifetch
    import pdp11_pkg::*;
#(
    parameter int PC_INC = 2,
    parameter int PC_SEL = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [2:0]        rf_sela,
    input  logic [WORD_W-1:0] rf_a,
    output logic [2:0]        rf_selb,
    output logic              rf_we,
    output logic [WORD_W-1:0] rf_w,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              busy,
    output logic              odd_err
);

    localparam logic [WORD_W-1:0] INC = WORD_W'(PC_INC);
    localparam logic [2:0]        SEL = 3'(PC_SEL);

    fetch_state_e      state;
    fetch_state_e      state_nx;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] addr_inc;

    assign rf_sela  = SEL;
    assign addr_inc = addr + INC;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            addr  <= '0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && fetch_en)
                addr <= rf_a;
            if (state == REQ && mem_ack)
                ir <= mem_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_addr = '0;
        rf_we    = 1'b0;
        rf_selb  = '0;
        rf_w     = '0;
        ir_valid = 1'b0;
        odd_err  = 1'b0;
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (fetch_en) begin
`ifdef IFETCH_ODD_TRAP_EN
                    state_nx = rf_a[0] ? ERR : REQ;
`else
                    state_nx = REQ;
`endif
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr;
                if (mem_ack)
                    state_nx = WB;
            end
            WB: begin
                rf_we    = 1'b1;
                rf_selb  = SEL;
                rf_w     = addr_inc;
                state_nx = HOLD;
            end
            HOLD: begin
                ir_valid = 1'b1;
                if (ir_ready)
                    state_nx = IDLE;
            end
`ifdef IFETCH_ODD_TRAP_EN
            ERR: begin
                odd_err  = 1'b1;
                state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL have parameter PC_INC, default 2, meaning the byte increment added to PC after each fetched word.
REQ-002 The block SHALL have parameter PC_SEL, default 7, meaning the register-file index used as PC.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous active-low reset (0 = reset).
REQ-006 The block SHALL have port fetch_en, input, 1 bit: level request to fetch the next instruction word.
REQ-007 The block SHALL have port rf_sela, output, 3 bits: register-file read select A; constant PC_SEL.
REQ-008 The block SHALL have port rf_a, input, 16 bits: register-file bus A (current PC).
REQ-009 The block SHALL have ports rf_selb (output, 3), rf_we (output, 1) and rf_w (output, 16): the register-file write port.
REQ-010 The block SHALL have ports mem_req (output, 1), mem_addr (output, 16), mem_ack (input, 1) and mem_rdata (input, 16): the memory read handshake.
REQ-011 The block SHALL have ports ir (output, 16), ir_valid (output, 1) and ir_ready (input, 1): the fetched-word handshake to the decoder.
REQ-012 The block SHALL have ports busy (output, 1) and odd_err (output, 1): busy = state not IDLE; odd_err = odd-PC trap pulse.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, WB, HOLD, and ERR (ERR only when trap is enabled).
REQ-014 In IDLE with fetch_en=1, the block SHALL latch rf_a into an internal address register and go to REQ next cycle.
REQ-015 In REQ, mem_req SHALL be 1 and mem_addr SHALL be the latched address, held stable until mem_ack=1.
REQ-016 On mem_ack=1 in REQ, ir SHALL capture mem_rdata and the FSM SHALL go to WB; mem_req SHALL be 0 from the next cycle.
REQ-017 In WB, for exactly one cycle, rf_we=1, rf_selb=PC_SEL and rf_w=(address+PC_INC) mod 2^16 (0xFFFE wraps to 0x0000).
REQ-018 Outside WB, rf_we SHALL be 0, and rf_selb and rf_w SHALL be 0.
REQ-019 In HOLD, ir_valid SHALL be 1 and ir SHALL be stable; on ir_valid&ir_ready the FSM SHALL go to IDLE.
REQ-020 With zero-wait memory, i.e. mem_ack=1 in the first REQ cycle, ir_valid SHALL rise 3 cycles after fetch_en is sampled in IDLE.
REQ-021 Back-to-back fetches SHALL run as HOLD→IDLE→REQ, with the new address taken from rf_a after the WB write has landed.
REQ-022 mem_ack outside REQ SHALL be ignored.
REQ-023 ir_ready outside HOLD SHALL be ignored.
REQ-024 fetch_en deasserted after leaving IDLE SHALL NOT abort the fetch in progress.

Reset
REQ-025 While reset=0 at a clock edge, the state SHALL become IDLE and mem_req, rf_we, ir_valid, busy and odd_err SHALL be 0.
REQ-026 While reset=0 at a clock edge, ir, mem_addr, rf_w, rf_selb and the address register SHALL be 0.
REQ-027 Reset mid-fetch SHALL abandon the memory request and SHALL NOT perform the PC write.
REQ-028 rf_sela SHALL equal PC_SEL during and after reset.
REQ-029 The PC register itself is cleared by the register file, not by this block.

Configuration
REQ-030 Macro IFETCH_ODD_TRAP_EN defined: in IDLE with fetch_en=1 and rf_a[0]=1, the FSM SHALL go to ERR instead of REQ.
REQ-031 With IFETCH_ODD_TRAP_EN defined: in ERR, odd_err=1 for exactly one cycle, with no mem_req and no PC write, then IDLE.
REQ-032 Macro undefined: there SHALL be no ERR state, odd_err SHALL be tied 0, and odd addresses SHALL be fetched unmodified.

Structure
REQ-033 Package pdp11_pkg SHALL hold the FSM state enum, register-index constants (REG_PC=7, REG_SP=6) and the word width (16).
REQ-034 No sub-module is required; the PC incrementer and FSM SHALL be inline in ifetch.

Verification
REQ-035 Bench scenario: rf_a=0x0100, fetch_en=1, mem_ack immediate, mem_rdata=0x15C0 -> mem_addr=0x0100; one-cycle write rf_selb=7, rf_w=0x0102; ir=0x15C0 with ir_valid 3 cycles after fetch_en.
REQ-036 Bench scenario: mem_ack delayed 4 cycles -> mem_req and mem_addr stable all 4 cycles; exactly one rf_we pulse.
REQ-037 Bench scenario: rf_a=0xFFFE -> rf_w=0x0000.
REQ-038 Bench scenario: ir_ready held 0 for 5 cycles in HOLD -> ir_valid=1 and ir constant; no new mem_req until the handshake.
REQ-039 Bench scenario: reset=0 asserted while in REQ -> next cycle IDLE, mem_req=0, rf_we never pulsed, ir=0.
REQ-040 Bench scenario, IFETCH_ODD_TRAP_EN defined: rf_a=0x0101, fetch_en=1 -> odd_err one-cycle pulse, mem_req=0, rf_we=0, back to IDLE.
